// File: rtl/bus_pkg.sv
// bus_pkg: shared constants and types for the system-bus arbiter.
//   NUM_SLAVES      : number of slave ports on the bus
//   SLV_MSB/SLV_LSB : address field that selects the slave
//   TIMEOUT_CYC_DEF : default DATA-phase limit (timeout build only)
//   state_t         : arbiter sequencing states
package bus_pkg;
    localparam int NUM_SLAVES      = 8;
    localparam int SLV_MSB         = 7;
    localparam int SLV_LSB         = 5;
    localparam int TIMEOUT_CYC_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;
endpackage

// File: rtl/slave_sel_dec.sv
// slave_sel_dec: combinational 3-to-8 one-hot decoder for the slave select.
//   sel    : slave index taken from the address select field
//   onehot : one-hot slave select, 3'b000 -> 8'h01 ... 3'b111 -> 8'h80
module slave_sel_dec
    import bus_pkg::*;
(
    input  logic [SLV_MSB-SLV_LSB:0] sel,
    output logic [NUM_SLAVES-1:0]    onehot
);
    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin arbiter and transaction sequencer for the shared
// 8-bit-address system bus.
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   M_req        : per-master request level, sampled only in IDLE
//   M_addr       : per-master address, master i at [8i+7:8i]
//   S_ready      : per-slave completion; only the selected slave's bit counts
//   M_grant      : registered one-hot grant
//   M_done       : one-cycle completion pulse to the granted master
//   bus_addr     : latched address of the granted master
//   S_sel        : registered one-hot slave select, zero when idle
//   bus_err      : one-cycle timeout pulse
// Optional feature: define BUS_TIMEOUT_EN to bound the DATA phase to
// TIMEOUT_CYC cycles; without it DATA waits forever and bus_err is 0.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_M       = 4,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_M-1:0]      M_req,
    input  logic [8*NUM_M-1:0]    M_addr,
    input  logic [NUM_SLAVES-1:0] S_ready,
    output logic [NUM_M-1:0]      M_grant,
    output logic [NUM_M-1:0]      M_done,
    output logic [7:0]            bus_addr,
    output logic [NUM_SLAVES-1:0] S_sel,
    output logic                  bus_err
);
    if (NUM_M < 2 || NUM_M > 4) begin : g_bad_num_m
        $error("bus_arbiter: NUM_M must be 2..4");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYC must be 1..255");
    end

    localparam logic [1:0]       LAST  = 2'(NUM_M - 1);
    localparam logic [NUM_M-1:0] ONE_M = NUM_M'(1);

    state_t                  state, state_nxt;
    logic [1:0]              rr_ptr, ptr_nxt;
    logic [1:0]              owner, owner_nxt;
    logic [NUM_M-1:0]        grant_nxt, done_nxt;
    logic [7:0]              addr_nxt;
    logic [NUM_SLAVES-1:0]   sel_nxt;
    logic                    err_nxt;

    // Round-robin search: candidates rr_ptr, rr_ptr+1, ... modulo NUM_M.
    logic                    win_vld;
    logic [1:0]              win_idx;
    logic [2:0]              cand;

    always_comb begin
        win_vld = 1'b0;
        win_idx = rr_ptr;
        cand    = '0;
        for (int k = 0; k < NUM_M; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'(NUM_M)) cand = cand - 3'(NUM_M);
            if (!win_vld && M_req[cand[1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[1:0];
            end
        end
    end

    logic [7:0]            win_addr;
    logic [NUM_SLAVES-1:0] win_sel;

    assign win_addr = M_addr[{win_idx, 3'b000} +: 8];

    slave_sel_dec u_dec (
        .sel    (win_addr[SLV_MSB:SLV_LSB]),
        .onehot (win_sel)
    );

    // Completion looks only at the slave addressed by the latched address.
    logic ready_sel;
    assign ready_sel = S_ready[bus_addr[SLV_MSB:SLV_LSB]];

    logic timeout;
`ifdef BUS_TIMEOUT_EN
    // Counter is 0 in the first DATA cycle; firing at TIMEOUT_CYC-1 gives a
    // DATA phase of exactly TIMEOUT_CYC cycles when the slave never answers.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
    logic [7:0] to_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)            to_cnt <= '0;
        else if (state == ADDR)  to_cnt <= '0;
        else if (state == DATA)  to_cnt <= to_cnt + 8'd1;
    end

    assign timeout = (state == DATA) && (to_cnt == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ptr_nxt   = rr_ptr;
        owner_nxt = owner;
        grant_nxt = M_grant;
        done_nxt  = '0;
        addr_nxt  = bus_addr;
        sel_nxt   = S_sel;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = ADDR;
                    owner_nxt = win_idx;
                    grant_nxt = ONE_M << win_idx;
                    addr_nxt  = win_addr;
                    sel_nxt   = win_sel;
                end
            end
            ADDR: state_nxt = DATA;
            DATA: begin
                // Completion beats a coincident timeout.
                if (ready_sel || timeout) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    sel_nxt   = '0;
                    done_nxt  = ready_sel ? M_grant : '0;
                    err_nxt   = !ready_sel;
                    ptr_nxt   = (owner == LAST) ? 2'd0 : owner + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            owner    <= '0;
            M_grant  <= '0;
            M_done   <= '0;
            bus_addr <= '0;
            S_sel    <= '0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= ptr_nxt;
            owner    <= owner_nxt;
            M_grant  <= grant_nxt;
            M_done   <= done_nxt;
            bus_addr <= addr_nxt;
            S_sel    <= sel_nxt;
            bus_err  <= err_nxt;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed self-checking bench for bus_arbiter (NUM_M=4,
// TIMEOUT_CYC=15). Runs in both builds; the timeout scenario adapts to
// BUS_TIMEOUT_EN.
module tb_bus_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  M_req;
    logic [31:0] M_addr;
    logic [7:0]  S_ready;
    logic [3:0]  M_grant, M_done;
    logic [7:0]  bus_addr, S_sel;
    logic        bus_err;

    int n_chk  = 0;
    int n_pass = 0;

    bus_arbiter #(.NUM_M(4), .TIMEOUT_CYC(15)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .M_req    (M_req),
        .M_addr   (M_addr),
        .S_ready  (S_ready),
        .M_grant  (M_grant),
        .M_done   (M_done),
        .bus_addr (bus_addr),
        .S_sel    (S_sel),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic set_addr(input int m, input logic [7:0] a);
        M_addr[8*m +: 8] = a;
    endtask

    // Round-robin table: addresses and their decoded slave selects.
    logic [7:0] rr_addr [4] = '{8'h25, 8'h41, 8'h60, 8'h9A};
    logic [7:0] rr_sel  [4] = '{8'h02, 8'h04, 8'h08, 8'h10};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int cnt;
        bit seen;

        reset_n = 1'b0;
        M_req   = '0;
        M_addr  = '0;
        S_ready = '0;
        tick(); tick();
        chk("rst_grant", M_grant, 4'b0000);
        chk("rst_done",  M_done,  4'b0000);
        chk("rst_addr",  bus_addr, 8'h00);
        chk("rst_sel",   S_sel,   8'h00);
        chk("rst_err",   bus_err, 1'b0);
        reset_n = 1'b1;
        tick();

        // Single master, slave 1, ready seen on the 3rd DATA edge -> 4-cycle grant.
        M_req = 4'b0001;
        set_addr(0, 8'h25);
        tick();
        chk("t1_grant", M_grant, 4'b0001);
        chk("t1_addr",  bus_addr, 8'h25);
        chk("t1_sel",   S_sel,    8'h02);
        // Request drop and address change must not disturb the locked transfer;
        // the other slaves' ready bits must be ignored.
        M_req   = 4'b0000;
        set_addr(0, 8'h00);
        S_ready = 8'hFD;
        tick(); tick(); tick();
        chk("t1_hold_grant", M_grant, 4'b0001);
        chk("t1_hold_addr",  bus_addr, 8'h25);
        chk("t1_hold_sel",   S_sel,    8'h02);
        chk("t1_hold_done",  M_done,   4'b0000);
        S_ready = 8'hFF;
        tick();
        chk("t1_done",   M_done,  4'b0001);
        chk("t1_clr_g",  M_grant, 4'b0000);
        chk("t1_clr_s",  S_sel,   8'h00);
        S_ready = 8'h00;
        tick();
        chk("t1_done_pulse", M_done, 4'b0000);

        // All four requesting; rr_ptr is now 1 -> 1,2,3,0,1 with an IDLE gap.
        for (int m = 0; m < 4; m++) set_addr(m, rr_addr[m]);
        M_req   = 4'b1111;
        S_ready = 8'hFF;
        for (int t = 0; t < 5; t++) begin
            idx = (t + 1) % 4;
            tick();
            chk("rr_grant", M_grant, 4'b0001 << idx);
            chk("rr_sel",   S_sel,   rr_sel[idx]);
            chk("rr_addr",  bus_addr, rr_addr[idx]);
            tick();
            chk("rr_grant2", M_grant, 4'b0001 << idx);
            if (t == 4) M_req = 4'b0000;
            tick();
            chk("rr_done",  M_done,  4'b0001 << idx);
            chk("rr_idle",  M_grant, 4'b0000);
        end

        // Slave 7, zero-wait: 2-cycle grant. rr_ptr is 2.
        set_addr(2, 8'hE5);
        M_req = 4'b0100;
        tick();
        chk("t3_grant", M_grant, 4'b0100);
        chk("t3_sel",   S_sel,   8'h80);
        chk("t3_addr",  bus_addr, 8'hE5);
        M_req = 4'b0000;
        tick();
        chk("t3_grant2", M_grant, 4'b0100);
        tick();
        chk("t3_done",  M_done,  4'b0100);
        chk("t3_clr",   M_grant, 4'b0000);
        S_ready = 8'h00;

        // Masters 0 and 3 request, slave never answers; rr_ptr is 3.
        set_addr(0, 8'h25);
        M_req = 4'b1001;
        tick();
        chk("t4_grant", M_grant, 4'b1000);
        chk("t4_sel",   S_sel,   8'h10);
`ifdef BUS_TIMEOUT_EN
        cnt  = 0;
        seen = 1'b0;
        while (cnt < 40 && !seen) begin
            tick();
            cnt++;
            if (bus_err) seen = 1'b1;
        end
        chk("t4_err_seen", seen, 1'b1);
        chk("t4_to_edges", cnt, 16);
        chk("t4_to_grant", M_grant, 4'b0000);
        chk("t4_to_sel",   S_sel,   8'h00);
        chk("t4_to_done",  M_done,  4'b0000);
        tick();
        chk("t4_err_pulse", bus_err, 1'b0);
`else
        cnt  = 0;
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (bus_err) seen = 1'b1;
        end
        chk("t4_no_err",  seen,    1'b0);
        chk("t4_waiting", M_grant, 4'b1000);
        S_ready = 8'h10;
        tick();
        chk("t4_done", M_done,  4'b1000);
        chk("t4_clr",  M_grant, 4'b0000);
        S_ready = 8'h00;
        tick();
`endif
        chk("t4_next_grant", M_grant, 4'b0001);
        chk("t4_next_sel",   S_sel,   8'h02);

        // Ready arrives on what would be the timeout edge: completion wins.
        M_req = 4'b0000;
        repeat (15) tick();
        chk("t5_pre_grant", M_grant, 4'b0001);
        S_ready = 8'h02;
        tick();
        chk("t5_done", M_done,  4'b0001);
        chk("t5_err",  bus_err, 1'b0);
        chk("t5_clr",  M_grant, 4'b0000);
        S_ready = 8'h00;

        // Reset mid-DATA with master 1 granted (rr_ptr 1).
        M_req = 4'b0011;
        tick();
        chk("t6_grant", M_grant, 4'b0010);
        chk("t6_sel",   S_sel,   8'h04);
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_grant", M_grant, 4'b0000);
        chk("t6_rst_sel",   S_sel,   8'h00);
        chk("t6_rst_addr",  bus_addr, 8'h00);
        chk("t6_rst_done",  M_done,  4'b0000);
        chk("t6_rst_err",   bus_err, 1'b0);
        #2 reset_n = 1'b1;
        tick();
        chk("t6_m0_grant", M_grant, 4'b0001);
        chk("t6_m0_addr",  bus_addr, 8'h25);
        M_req   = 4'b0000;
        S_ready = 8'hFF;
        tick(); tick();
        chk("t6_m0_done", M_done, 4'b0001);
        S_ready = 8'h00;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
